// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forwarding/control inputs and EX-side outputs of the ID/EX register.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int ALUOP_WIDTH = 8
);
    logic                   id_valid_i;
    logic [DATA_WIDTH-1:0]  id_pc_i;
    logic [ADDR_WIDTH-1:0]  id_reg1_raddr_i;
    logic [ADDR_WIDTH-1:0]  id_reg2_raddr_i;
    logic                   id_reg1_re_i;
    logic                   id_reg2_re_i;
    logic [DATA_WIDTH-1:0]  id_reg1_rdata_i;
    logic [DATA_WIDTH-1:0]  id_reg2_rdata_i;
    logic [DATA_WIDTH-1:0]  id_imm_i;
    logic                   id_use_imm_i;
    logic [ALUOP_WIDTH-1:0] id_alu_op_i;
    logic [ADDR_WIDTH-1:0]  id_reg_waddr_i;
    logic                   id_reg_we_i;
    logic                   id_is_load_i;
    logic                   fw_en1_i;
    logic                   fw_en2_i;
    logic [DATA_WIDTH-1:0]  fw_data1_i;
    logic [DATA_WIDTH-1:0]  fw_data2_i;
    logic                   flush_i;
    logic                   mem_stall_i;
    logic                   stall_req_o;
    logic                   ex_valid_o;
    logic [DATA_WIDTH-1:0]  ex_pc_o;
    logic [DATA_WIDTH-1:0]  ex_op1_o;
    logic [DATA_WIDTH-1:0]  ex_op2_o;
    logic [DATA_WIDTH-1:0]  ex_rs2_data_o;
    logic [ALUOP_WIDTH-1:0] ex_alu_op_o;
    logic [ADDR_WIDTH-1:0]  ex_reg_waddr_o;
    logic                   ex_reg_we_o;
    logic                   ex_is_load_o;
    logic [31:0]            bubble_cnt_o;

    modport master (
        output id_valid_i, id_pc_i, id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_re_i, id_reg2_re_i,
               id_reg1_rdata_i, id_reg2_rdata_i, id_imm_i, id_use_imm_i, id_alu_op_i,
               id_reg_waddr_i, id_reg_we_i, id_is_load_i, fw_en1_i, fw_en2_i, fw_data1_i,
               fw_data2_i, flush_i, mem_stall_i,
        input  stall_req_o, ex_valid_o, ex_pc_o, ex_op1_o, ex_op2_o, ex_rs2_data_o, ex_alu_op_o,
               ex_reg_waddr_o, ex_reg_we_o, ex_is_load_o, bubble_cnt_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_reg1_raddr_i, id_reg2_raddr_i, id_reg1_re_i, id_reg2_re_i,
               id_reg1_rdata_i, id_reg2_rdata_i, id_imm_i, id_use_imm_i, id_alu_op_i,
               id_reg_waddr_i, id_reg_we_i, id_is_load_i, fw_en1_i, fw_en2_i, fw_data1_i,
               fw_data2_i, flush_i, mem_stall_i,
        output stall_req_o, ex_valid_o, ex_pc_o, ex_op1_o, ex_op2_o, ex_rs2_data_o, ex_alu_op_o,
               ex_reg_waddr_o, ex_reg_we_o, ex_is_load_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand build, load-use bubble and flush/stall handling.
// Defining ID_EX_BUBBLE_CNT_EN adds a saturating load-use bubble counter on bubble_cnt_o.
module id_ex_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int ALUOP_WIDTH = 8
) (
    input logic         clk_i,
    input logic         rst_n_i,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic                   valid;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  op1;
        logic [DATA_WIDTH-1:0]  op2;
        logic [DATA_WIDTH-1:0]  rs2_data;
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic [ADDR_WIDTH-1:0]  reg_waddr;
        logic                   reg_we;
        logic                   is_load;
    } ex_t;

    logic [DATA_WIDTH-1:0] src1, src2;
    logic                  hit;
    ex_t                   cap, ex_d, ex_q;

    always_comb begin
        src1 = !bus.id_reg1_re_i ? '0 : bus.fw_en1_i ? bus.fw_data1_i :
               (bus.id_reg1_raddr_i == '0) ? '0 : bus.id_reg1_rdata_i;
        src2 = !bus.id_reg2_re_i ? '0 : bus.fw_en2_i ? bus.fw_data2_i :
               (bus.id_reg2_raddr_i == '0) ? '0 : bus.id_reg2_rdata_i;
        // a load in EX whose rd is read by ID cannot be forwarded until it reaches MEM
        hit = ex_q.valid & ex_q.is_load & ex_q.reg_we & (ex_q.reg_waddr != '0) & bus.id_valid_i &
              ((bus.id_reg1_re_i & (bus.id_reg1_raddr_i == ex_q.reg_waddr)) |
               (bus.id_reg2_re_i & (bus.id_reg2_raddr_i == ex_q.reg_waddr)));
        cap.valid     = bus.id_valid_i;
        cap.pc        = bus.id_pc_i;
        cap.op1       = src1;
        cap.op2       = bus.id_use_imm_i ? bus.id_imm_i : src2;
        cap.rs2_data  = src2;
        cap.alu_op    = bus.id_alu_op_i;
        cap.reg_waddr = bus.id_reg_waddr_i;
        cap.reg_we    = bus.id_valid_i & bus.id_reg_we_i;
        cap.is_load   = bus.id_valid_i & bus.id_is_load_i;
        ex_d = bus.mem_stall_i ? ex_q : (bus.flush_i | hit) ? ex_t'('0) : cap;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    assign bus.stall_req_o    = hit & !bus.flush_i;
    assign bus.ex_valid_o     = ex_q.valid;
    assign bus.ex_pc_o        = ex_q.pc;
    assign bus.ex_op1_o       = ex_q.op1;
    assign bus.ex_op2_o       = ex_q.op2;
    assign bus.ex_rs2_data_o  = ex_q.rs2_data;
    assign bus.ex_alu_op_o    = ex_q.alu_op;
    assign bus.ex_reg_waddr_o = ex_q.reg_waddr;
    assign bus.ex_reg_we_o    = ex_q.reg_we;
    assign bus.ex_is_load_o   = ex_q.is_load;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    always_comb
        bubble_cnt_d = (!bus.mem_stall_i & !bus.flush_i & hit & (bubble_cnt_q != '1)) ?
                       bubble_cnt_q + 32'd1 : bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) bubble_cnt_q <= '0;
        else          bubble_cnt_q <= bubble_cnt_d;
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
`else
    assign bus.bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenario tasks with hand-computed expectations for id_ex_stage.
module tb_id_ex_stage;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam int CNT_STEP = 1;
`else
    localparam int CNT_STEP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    id_ex_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ALUOP_WIDTH(8)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ALUOP_WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // {valid, pc, op1, op2, rs2_data, alu_op, waddr, we, is_load}
    logic [143:0] ex_all;
    assign ex_all = {bus.ex_valid_o, bus.ex_pc_o, bus.ex_op1_o, bus.ex_op2_o, bus.ex_rs2_data_o,
                     bus.ex_alu_op_o, bus.ex_reg_waddr_o, bus.ex_reg_we_o, bus.ex_is_load_o};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic re1, input logic re2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic ui, input logic [7:0] op, input logic [4:0] rd,
                          input logic we, input logic ld);
        bus.id_valid_i = v;      bus.id_pc_i = pc;
        bus.id_reg1_raddr_i = rs1; bus.id_reg2_raddr_i = rs2;
        bus.id_reg1_re_i = re1;  bus.id_reg2_re_i = re2;
        bus.id_reg1_rdata_i = d1; bus.id_reg2_rdata_i = d2;
        bus.id_imm_i = imm;      bus.id_use_imm_i = ui;
        bus.id_alu_op_i = op;    bus.id_reg_waddr_i = rd;
        bus.id_reg_we_i = we;    bus.id_is_load_i = ld;
    endtask

    task automatic set_ctl(input logic fe1, input logic [31:0] fd1, input logic fl, input logic ms);
        bus.fw_en1_i = fe1; bus.fw_data1_i = fd1;
        bus.fw_en2_i = 1'b0; bus.fw_data2_i = 32'h0;
        bus.flush_i = fl;   bus.mem_stall_i = ms;
    endtask

    task automatic test_reset();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h40, 5'd1, 5'd2, 1, 1, 32'h11, 32'h22, 0, 0, 8'h01, 5'd9, 1, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (ex_all !== {1'b1, 32'h40, 32'h11, 32'h22, 32'h22, 8'h01, 5'd9, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL pre_reset_capture: got %h want %h", ex_all,
                {1'b1, 32'h40, 32'h11, 32'h22, 32'h22, 8'h01, 5'd9, 1'b1, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ex_all, bus.bubble_cnt_o, bus.stall_req_o} !== '0) begin
            n_err++; $display("FAIL async_reset: got %h/%h/%b want all zero", ex_all, bus.bubble_cnt_o, bus.stall_req_o);
        end
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (ex_all !== '0) begin
            n_err++; $display("FAIL reset_held: got %h want 0", ex_all);
        end
    endtask

    task automatic test_capture();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h100, 5'd1, 5'd2, 1, 1, 32'd5, 32'd7, 32'h0, 0, 8'h10, 5'd3, 1, 0);
        n_cmp++;
        if (bus.stall_req_o !== 1'b0) begin
            n_err++; $display("FAIL capture_nostall: got %b want 0", bus.stall_req_o);
        end
        tick();
        n_cmp++;
        if (ex_all !== {1'b1, 32'h100, 32'd5, 32'd7, 32'd7, 8'h10, 5'd3, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL capture_add: got %h want %h", ex_all,
                {1'b1, 32'h100, 32'd5, 32'd7, 32'd7, 8'h10, 5'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_forward();
        set_ctl(1, 32'hDEAD, 0, 0);
        set_id(1, 32'h104, 5'd1, 5'd0, 1, 0, 32'h1, 32'h77, 32'h10, 1, 8'h20, 5'd4, 1, 0);
        tick();
        n_cmp++;
        if (ex_all !== {1'b1, 32'h104, 32'hDEAD, 32'h10, 32'h0, 8'h20, 5'd4, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL forward_addi: got %h want %h", ex_all,
                {1'b1, 32'h104, 32'hDEAD, 32'h10, 32'h0, 8'h20, 5'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_invalid();
        set_ctl(0, 0, 0, 0);
        set_id(0, 32'h108, 5'd1, 5'd2, 1, 1, 32'h3, 32'h4, 32'h0, 0, 8'h05, 5'd5, 1, 1);
        tick();
        n_cmp++;
        if ({bus.ex_valid_o, bus.ex_reg_we_o, bus.ex_is_load_o, bus.ex_op1_o} !== {3'b000, 32'h3}) begin
            n_err++; $display("FAIL invalid_forces_we: got %b%b%b/%h want 000/3",
                bus.ex_valid_o, bus.ex_reg_we_o, bus.ex_is_load_o, bus.ex_op1_o);
        end
    endtask

    task automatic test_load_use();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h200, 5'd1, 5'd0, 1, 0, 32'h1000, 0, 32'h4, 1, 8'h30, 5'd5, 1, 1);
        tick();
        set_id(1, 32'h204, 5'd5, 5'd0, 1, 1, 32'hBAD, 32'h0, 0, 0, 8'h10, 5'd6, 1, 0);
        #1;
        n_cmp++;
        if (bus.stall_req_o !== 1'b1) begin
            n_err++; $display("FAIL loaduse_stall: got %b want 1", bus.stall_req_o);
        end
        tick();
        n_cmp++;
        if ({bus.ex_valid_o, bus.ex_reg_we_o, bus.ex_is_load_o, bus.ex_pc_o, bus.stall_req_o} !== {3'b000, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL loaduse_bubble: got %b%b%b/%h/%b want 000/0/0",
                bus.ex_valid_o, bus.ex_reg_we_o, bus.ex_is_load_o, bus.ex_pc_o, bus.stall_req_o);
        end
        set_ctl(1, 32'h99, 0, 0);
        tick();
        n_cmp++;
        if (ex_all !== {1'b1, 32'h204, 32'h99, 32'h0, 32'h0, 8'h10, 5'd6, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL loaduse_resume: got %h want %h", ex_all,
                {1'b1, 32'h204, 32'h99, 32'h0, 32'h0, 8'h10, 5'd6, 1'b1, 1'b0});
        end
        n_cmp++;
        if (bus.bubble_cnt_o !== 32'(CNT_STEP)) begin
            n_err++; $display("FAIL loaduse_count: got %0d want %0d", bus.bubble_cnt_o, CNT_STEP);
        end
    endtask

    task automatic test_flush_hit();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h300, 5'd1, 5'd0, 1, 0, 32'h1000, 0, 32'h8, 1, 8'h30, 5'd5, 1, 1);
        tick();
        set_ctl(0, 0, 1, 0);
        set_id(1, 32'h304, 5'd5, 5'd0, 1, 1, 32'h0, 32'h0, 0, 0, 8'h10, 5'd6, 1, 0);
        #1;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0) begin
            n_err++; $display("FAIL flush_nostall: got %b want 0", bus.stall_req_o);
        end
        tick();
        n_cmp++;
        if ({ex_all, bus.bubble_cnt_o} !== {144'h0, 32'(CNT_STEP)}) begin
            n_err++; $display("FAIL flush_bubble: got %h/%0d want 0/%0d", ex_all, bus.bubble_cnt_o, CNT_STEP);
        end
    endtask

    task automatic test_mem_stall();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h400, 5'd1, 5'd2, 1, 1, 32'd10, 32'd20, 0, 0, 8'h11, 5'd7, 1, 0);
        tick();
        set_ctl(0, 0, 1, 1);
        set_id(1, 32'h404, 5'd3, 5'd4, 1, 1, 32'd1, 32'd2, 0, 0, 8'h22, 5'd8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ex_all !== {1'b1, 32'h400, 32'd10, 32'd20, 32'd20, 8'h11, 5'd7, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL mem_stall_hold[%0d]: got %h want %h", i, ex_all,
                    {1'b1, 32'h400, 32'd10, 32'd20, 32'd20, 8'h11, 5'd7, 1'b1, 1'b0});
            end
        end
        bus.mem_stall_i = 1'b0;
        tick();
        n_cmp++;
        if (ex_all !== '0) begin
            n_err++; $display("FAIL mem_stall_flush: got %h want 0", ex_all);
        end
    endtask

    task automatic test_stall_hit();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h500, 5'd1, 5'd0, 1, 0, 32'h0, 0, 32'h0, 1, 8'h30, 5'd9, 1, 1);
        tick();
        set_ctl(0, 0, 0, 1);
        set_id(1, 32'h504, 5'd2, 5'd9, 1, 1, 32'h0, 32'h0, 0, 0, 8'h10, 5'd6, 1, 0);
        tick();
        n_cmp++;
        if ({bus.stall_req_o, bus.ex_valid_o, bus.ex_is_load_o, bus.ex_pc_o} !== {3'b111, 32'h500}) begin
            n_err++; $display("FAIL stall_hit_hold: got %b%b%b/%h want 111/500",
                bus.stall_req_o, bus.ex_valid_o, bus.ex_is_load_o, bus.ex_pc_o);
        end
        bus.mem_stall_i = 1'b0;
        tick();
        n_cmp++;
        if ({bus.ex_valid_o, bus.stall_req_o, bus.bubble_cnt_o} !== {2'b00, 32'(2 * CNT_STEP)}) begin
            n_err++; $display("FAIL stall_hit_bubble: got %b%b/%0d want 00/%0d",
                bus.ex_valid_o, bus.stall_req_o, bus.bubble_cnt_o, 2 * CNT_STEP);
        end
    endtask

    task automatic test_x0();
        set_ctl(0, 0, 0, 0);
        set_id(1, 32'h600, 5'd0, 5'd2, 1, 1, 32'h55, 32'h3, 0, 0, 8'h10, 5'd0, 1, 1);
        tick();
        n_cmp++;
        if ({bus.ex_op1_o, bus.ex_op2_o, bus.ex_is_load_o} !== {32'h0, 32'h3, 1'b1}) begin
            n_err++; $display("FAIL x0_read: got %h/%h/%b want 0/3/1", bus.ex_op1_o, bus.ex_op2_o, bus.ex_is_load_o);
        end
        set_id(1, 32'h604, 5'd0, 5'd0, 1, 1, 32'h55, 32'h0, 0, 0, 8'h10, 5'd6, 1, 0);
        #1;
        n_cmp++;
        if (bus.stall_req_o !== 1'b0) begin
            n_err++; $display("FAIL x0_load_nostall: got %b want 0", bus.stall_req_o);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_invalid();
        test_load_use();
        test_flush_hit();
        test_mem_stall();
        test_stall_hit();
        test_x0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the RV32 core.
- Builds the final EX operands from register-file read data, forwarding overrides and the immediate, then registers them with the rest of the decoded control.
- Detects load-use hazards: it inserts a one-cycle bubble and requests an upstream stall.
- Honours branch flush and downstream memory stall.

Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- ADDR_WIDTH, 5, register address width
- ALUOP_WIDTH, 8, ALU opcode width

Ports:
- clk_i  in  1  core clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  DATA_WIDTH  PC of ID instruction
- id_reg1_raddr_i  in  ADDR_WIDTH  rs1 address
- id_reg2_raddr_i  in  ADDR_WIDTH  rs2 address
- id_reg1_re_i  in  1  rs1 read enable
- id_reg2_re_i  in  1  rs2 read enable
- id_reg1_rdata_i  in  DATA_WIDTH  regfile rs1 data
- id_reg2_rdata_i  in  DATA_WIDTH  regfile rs2 data
- id_imm_i  in  DATA_WIDTH  decoded immediate
- id_use_imm_i  in  1  op2 takes immediate
- id_alu_op_i  in  ALUOP_WIDTH  ALU opcode
- id_reg_waddr_i  in  ADDR_WIDTH  rd
- id_reg_we_i  in  1  rd write enable
- id_is_load_i  in  1  instruction is a load
- fw_en1_i / fw_en2_i  in  1 each  forwarding valid for rs1/rs2
- fw_data1_i / fw_data2_i  in  DATA_WIDTH each  forwarded values
- flush_i  in  1  branch/jump taken in EX
- mem_stall_i  in  1  downstream stall, hold stage
- stall_req_o  out  1  freeze PC and IF/ID (combinational)
- ex_valid_o  out  1  EX instruction valid
- ex_pc_o  out  DATA_WIDTH
- ex_op1_o  out  DATA_WIDTH
- ex_op2_o  out  DATA_WIDTH
- ex_rs2_data_o  out  DATA_WIDTH  store data (never the immediate)
- ex_alu_op_o  out  ALUOP_WIDTH
- ex_reg_waddr_o  out  ADDR_WIDTH
- ex_reg_we_o  out  1
- ex_is_load_o  out  1
- bubble_cnt_o  out  32  load-use bubble count (see Optional Feature)

Behaviour:
- Reset (async, rst_n_i=0): every registered output cleared to 0, including ex_valid_o, ex_reg_we_o and ex_is_load_o; counter cleared. Reset mid-stall drops the held instruction.
- Operand build (combinational, ID side):
  - src1 = fw_en1_i ? fw_data1_i : (rs1==0 ? 0 : id_reg1_rdata_i); src1 forced to 0 when id_reg1_re_i=0.
  - src2 is built the same way from the rs2 signals.
  - op1 = src1; op2 = id_use_imm_i ? id_imm_i : src2; rs2_data = src2.
- Load-use hit: ex_valid_o & ex_is_load_o & ex_reg_we_o & ex_reg_waddr_o!=0 & ((id_reg1_re_i & rs1==ex_reg_waddr_o) | (id_reg2_re_i & rs2==ex_reg_waddr_o)) & id_valid_i.
- stall_req_o = hit & !flush_i. A wrong-path instruction never stalls.
- Register update each rising edge, in priority order:
  1. mem_stall_i=1: hold all outputs.
  2. flush_i=1: load a bubble (valid=0, we=0, is_load=0; data fields 0).
  3. hit=1: load a bubble. The next cycle the load is in MEM, the hit clears and the forwarding path supplies the data. Exactly one bubble per load-use pair.
  4. Otherwise capture the ID fields; ex_valid_o=id_valid_i. If id_valid_i=0, we and is_load are forced to 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- Bubble fields: all zero. A bubble never asserts ex_reg_we_o.
- mem_stall_i and hit together: hold; stall_req_o still asserted.
- mem_stall_i and flush_i together: hold; flush applied on the first unstalled edge (EX keeps flush_i high while the branch is held).

Optional Feature:
- Macro ID_EX_BUBBLE_CNT_EN.
- Defined: 32-bit counter increments on each edge that loads a load-use bubble (case 3 only; flush bubbles are not counted). It saturates at 0xFFFFFFFF and drives bubble_cnt_o.
- Undefined: no counter logic; bubble_cnt_o tied to 0.

Test Plan:
- Reset then capture: assert rst_n_i=0 mid-stream, then release. Capture add x3,x1,x2 (pc=0x100, x1=5, x2=7, no fw) -> next cycle ex_valid_o=1, ex_op1_o=5, ex_op2_o=7, ex_reg_waddr_o=3; after reset all outputs are 0.
- Forward override: fw_en1_i=1, fw_data1_i=0xDEAD, regfile rs1=0x1; addi x4,x1,0x10 -> ex_op1_o=0xDEAD, ex_op2_o=0x10.
- Load-use: EX holds lw x5 (we=1, load=1); ID has add x6,x5,x0 -> stall_req_o=1 for one cycle, then ex_valid_o=0 bubble. Next cycle stall_req_o=0 and the add is captured; bubble_cnt_o=1 with macro, 0 without.
- Flush vs hit: same load-use case with flush_i=1 -> stall_req_o=0, bubble loaded, bubble_cnt_o unchanged.
- Mem stall hold: mem_stall_i=1 for 3 cycles with flush_i=1 -> outputs unchanged all 3 cycles; bubble appears on the first edge after mem_stall_i drops.
- x0 rule: rs1=0, regfile returns 0x55 (bus glitch), fw_en1_i=0 -> ex_op1_o=0; rd=x0 load in EX does not trigger a stall.
